mips_exec_mem: RTL and testbench
================================

Name: mips_exec_mem

Overview:
- Execute/memory slice of the single-cycle MIPS core.
- Contains the main control decoder, the 32-bit ALU and a 32-word data memory.
- Takes decoded instruction fields and register/extender operands; returns control strobes, ALU result, zero flag and write-back data.
- Sits between the register file/extender and the register-file write port; PC logic consumes jump/branch/zero.

Parameters:
- DM_WORDS, 32, data memory depth in 32-bit words (power of two).
- DM_AW, 5, data memory word-address width, log2(DM_WORDS).

Ports:
- clk  in  1  clock; memory writes occur on the rising edge.
- reset  in  1  asynchronous, active-high; clears the data memory.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- rs_data  in  32  GPR read port 1; ALU operand A.
- rt_data  in  32  GPR read port 2; ALU operand B when alusrc=0; store data.
- ext_data  in  32  extender output; ALU operand B when alusrc=1.
- jump  out  1  j instruction.
- reg_dst  out  1  1 = write rd, 0 = write rt.
- branch  out  1  beq.
- mem_r  out  1  load.
- mem2r  out  1  write-back selects memory.
- mem_w  out  1  store.
- reg_w  out  1  GPR write enable.
- alusrc  out  1  ALU B = ext_data.
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- alu_ctrl  out  5  ALU operation code.
- alu_result  out  32  ALU output.
- zero  out  1  alu_result == 0.
- wb_data  out  32  mem2r ? dm_out : alu_result.

Behaviour:
- Datapath is combinational except the memory write; single-cycle, zero latency.
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLLV, 9 SRLV, 10 SRAV, 11 PASSB.
  - All other codes output 0.
  - ADD/SUB wrap mod 2^32; no overflow trap.
  - Shifts compute B shifted by A[4:0].
  - SLT/SLTU output 32'd1 or 32'd0.
- R-type (op=000000) decode: reg_dst=1, reg_w=1, alusrc=0.
  - funct: 100000 add, 100001 addu → ADD; 100010 sub, 100011 subu → SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU; 000100 SLLV; 000110 SRLV; 000111 SRAV.
- I-type decode: reg_w=1, reg_dst=0, alusrc=1 unless noted.
  - addi 001000, addiu 001001: ADD, ext 01.
  - andi 001100, ori 001101, xori 001110: AND/OR/XOR, ext 00.
  - lui 001111: PASSB, ext 10.
  - slti 001010: SLT, ext 01.
  - sltiu 001011: SLTU, ext 01.
  - lw 100011: ADD, ext 01, mem_r=1, mem2r=1.
  - sw 101011: ADD, ext 01, mem_w=1, reg_w=0.
  - beq 000100: SUB, alusrc=0, branch=1, reg_w=0, ext 01.
  - j 000010: jump=1, all other strobes 0.
- Unknown op or R-type funct: all strobes 0, alu_ctrl=ADD, ext_op=00 (acts as NOP).
- Data memory addressing: word address = alu_result[DM_AW+1:2]; higher address bits ignored, so addresses wrap.
- Data memory read: combinational; dm_out = mem_r ? mem[addr] : 0.
- Data memory write: mem[addr] <= rt_data on rising clk when mem_w=1.
- Reset: asserting reset clears every memory word to 0 immediately. While reset is high, writes are blocked. Reset dominates a simultaneous write.
- Read of an address written on the same edge returns the new value after the edge.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct constants;
  - the ALU-code enum (5 bits);
  - the ext_op encodings.
- Natural sub-modules: mips_ctrl_dec (pure combinational decoder); the ALU and memory stay inline.

Test Plan:
- R-type add, rs=0x7FFFFFFF, rt=1 → alu_result=0x80000000, reg_w=1, reg_dst=1, zero=0. Same operands with sub → 0x7FFFFFFE.
- slt with rs=0xFFFFFFFF, rt=1 → 1. sltu with the same operands → 0. srav with rs=4, rt=0x80000000 → 0xF8000000.
- sw with rs=0, ext_data=8, rt_data=0xDEADBEEF, then lw with the same address → wb_data=0xDEADBEEF, mem2r=1, mem_r=1. Same lw with mem_r forced by an unknown op → wb_data=alu_result.
- beq with rs=rt=5 → branch=1, zero=1, reg_w=0. With rt=6 → zero=0.
- j → jump=1, all other strobes 0. op=111111 → all strobes 0. lui with ext_data=0x12340000 → alu_result=0x12340000, ext_op=10.
- Store 0x55 to word 3, then pulse reset between clock edges → lw of word 3 returns 0. A store issued during reset is not written.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU operation codes and control bundle shared by the exec/mem slice.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c,
                           OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07, F_ADD = 6'h20,
                           F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                           F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;
    typedef enum logic [4:0] {
        ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3, ALU_XOR = 5'd4, ALU_NOR = 5'd5,
        ALU_SLT = 5'd6, ALU_SLTU = 5'd7, ALU_SLLV = 5'd8, ALU_SRLV = 5'd9, ALU_SRAV = 5'd10, ALU_PASSB = 5'd11
    } alu_op_e;
    typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_LUI = 2'b10} ext_op_e;
    typedef struct packed {
        logic    jump;
        logic    reg_dst;
        logic    branch;
        logic    mem_r;
        logic    mem2r;
        logic    mem_w;
        logic    reg_w;
        logic    alusrc;
        ext_op_e ext_op;
        alu_op_e alu_ctrl;
    } ctrl_t;
endpackage

// File: rtl/mips_exec_mem_if.sv
// mips_exec_mem_if: decoded-instruction operands in, control strobes and datapath results out.
interface mips_exec_mem_if;
    import mips_pkg::*;
    logic [5:0]  op, funct;
    logic [31:0] rs_data, rt_data, ext_data;
    logic        jump, reg_dst, branch, mem_r, mem2r, mem_w, reg_w, alusrc, zero;
    ext_op_e     ext_op;
    alu_op_e     alu_ctrl;
    logic [31:0] alu_result, wb_data;
    modport master (
        output op, funct, rs_data, rt_data, ext_data,
        input  jump, reg_dst, branch, mem_r, mem2r, mem_w, reg_w, alusrc, ext_op, alu_ctrl, alu_result, zero, wb_data
    );
    modport slave (
        input  op, funct, rs_data, rt_data, ext_data,
        output jump, reg_dst, branch, mem_r, mem2r, mem_w, reg_w, alusrc, ext_op, alu_ctrl, alu_result, zero, wb_data
    );
endinterface

// File: rtl/mips_ctrl_dec.sv
// mips_ctrl_dec: combinational main decoder; unknown opcodes and R-type functs decode to a NOP.
module mips_ctrl_dec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);
    alu_op_e r_alu;
    logic    r_ok, r_op, i_alu;
    always_comb begin
        r_ok = 1'b1;
        r_alu = ALU_ADD;
        case (funct)
            F_ADD, F_ADDU: r_alu = ALU_ADD;
            F_SUB, F_SUBU: r_alu = ALU_SUB;
            F_AND:         r_alu = ALU_AND;
            F_OR:          r_alu = ALU_OR;
            F_XOR:         r_alu = ALU_XOR;
            F_NOR:         r_alu = ALU_NOR;
            F_SLT:         r_alu = ALU_SLT;
            F_SLTU:        r_alu = ALU_SLTU;
            F_SLLV:        r_alu = ALU_SLLV;
            F_SRLV:        r_alu = ALU_SRLV;
            F_SRAV:        r_alu = ALU_SRAV;
            default:       r_ok = 1'b0;
        endcase
    end
    assign r_op  = (op == OP_RTYPE) && r_ok;
    // immediate-operand instructions that write the ALU or load result back to rt
    assign i_alu = op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU, OP_LW};
    always_comb begin
        ctrl = '0;
        ctrl.jump = op == OP_J;
        ctrl.reg_dst = r_op;
        ctrl.branch = op == OP_BEQ;
        ctrl.mem_r = op == OP_LW;
        ctrl.mem2r = op == OP_LW;
        ctrl.mem_w = op == OP_SW;
        ctrl.reg_w = r_op | i_alu;
        ctrl.alusrc = i_alu | (op == OP_SW);
        ctrl.ext_op = EXT_ZERO;
        ctrl.alu_ctrl = ALU_ADD;
        case (op)
            OP_RTYPE:                        ctrl.alu_ctrl = r_alu;
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: ctrl.ext_op = EXT_SIGN;
            OP_ANDI:                         ctrl.alu_ctrl = ALU_AND;
            OP_ORI:                          ctrl.alu_ctrl = ALU_OR;
            OP_XORI:                         ctrl.alu_ctrl = ALU_XOR;
            OP_LUI:  begin ctrl.alu_ctrl = ALU_PASSB; ctrl.ext_op = EXT_LUI;  end
            OP_SLTI: begin ctrl.alu_ctrl = ALU_SLT;   ctrl.ext_op = EXT_SIGN; end
            OP_SLTIU:begin ctrl.alu_ctrl = ALU_SLTU;  ctrl.ext_op = EXT_SIGN; end
            OP_BEQ:  begin ctrl.alu_ctrl = ALU_SUB;   ctrl.ext_op = EXT_SIGN; end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_exec_mem.sv
// mips_exec_mem: single-cycle execute/memory slice -- decoder, 32-bit ALU and word-addressed data memory.
module mips_exec_mem
    import mips_pkg::*;
#(
    parameter int DM_WORDS = 32,
    parameter int DM_AW    = $clog2(DM_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    mips_exec_mem_if.slave  bus
);
    ctrl_t             c;
    logic [31:0]       a, b, y, dm_out;
    logic [DM_AW-1:0]  addr;
    logic [31:0]       mem [DM_WORDS];
    mips_ctrl_dec u_dec (.op(bus.op), .funct(bus.funct), .ctrl(c));
    assign a = bus.rs_data;
    assign b = c.alusrc ? bus.ext_data : bus.rt_data;
    always_comb begin
        y = '0;
        case (c.alu_ctrl)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOR:   y = ~(a | b);
            ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {31'd0, a < b};
            ALU_SLLV:  y = b << a[4:0];
            ALU_SRLV:  y = b >> a[4:0];
            ALU_SRAV:  y = $signed(b) >>> a[4:0];
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end
    // byte address -> word address; upper bits drop so accesses wrap
    assign addr = y[DM_AW+1:2];
    assign dm_out = c.mem_r ? mem[addr] : '0;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        else if (c.mem_w)
            mem[addr] <= bus.rt_data;
    assign bus.jump = c.jump;
    assign bus.reg_dst = c.reg_dst;
    assign bus.branch = c.branch;
    assign bus.mem_r = c.mem_r;
    assign bus.mem2r = c.mem2r;
    assign bus.mem_w = c.mem_w;
    assign bus.reg_w = c.reg_w;
    assign bus.alusrc = c.alusrc;
    assign bus.ext_op = c.ext_op;
    assign bus.alu_ctrl = c.alu_ctrl;
    assign bus.alu_result = y;
    assign bus.zero = y == '0;
    assign bus.wb_data = c.mem2r ? dm_out : y;
endmodule

// File: tb/tb_mips_exec_mem.sv
// tb_mips_exec_mem: random and directed instructions checked every cycle against a table-driven model.
module tb_mips_exec_mem;
    typedef struct packed {
        logic jump, reg_dst, branch, mem_r, mem2r, mem_w, reg_w, alusrc;
        logic [1:0] ext;
        logic [4:0] alu;
    } ectl_t;
    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mm [32];
    mips_exec_mem_if bus();
    mips_exec_mem dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    function automatic ectl_t ctl_model(input logic [5:0] o, input logic [5:0] f);
        ectl_t e;
        int r;
        case (f)
            6'h20, 6'h21: r = 0;
            6'h22, 6'h23: r = 1;
            6'h24: r = 2;
            6'h25: r = 3;
            6'h26: r = 4;
            6'h27: r = 5;
            6'h2a: r = 6;
            6'h2b: r = 7;
            6'h04: r = 8;
            6'h06: r = 9;
            6'h07: r = 10;
            default: r = -1;
        endcase
        case (o)
            6'h00:        e = (r >= 0) ? {8'b01000010, 2'b00, 5'(r)} : '0;
            6'h08, 6'h09: e = {8'b00000011, 2'b01, 5'd0};
            6'h0c:        e = {8'b00000011, 2'b00, 5'd2};
            6'h0d:        e = {8'b00000011, 2'b00, 5'd3};
            6'h0e:        e = {8'b00000011, 2'b00, 5'd4};
            6'h0f:        e = {8'b00000011, 2'b10, 5'd11};
            6'h0a:        e = {8'b00000011, 2'b01, 5'd6};
            6'h0b:        e = {8'b00000011, 2'b01, 5'd7};
            6'h23:        e = {8'b00011011, 2'b01, 5'd0};
            6'h2b:        e = {8'b00000101, 2'b01, 5'd0};
            6'h04:        e = {8'b00100000, 2'b01, 5'd1};
            6'h02:        e = {8'b10000000, 2'b00, 5'd0};
            default:      e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] alu_model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        logic [31:0] r;
        s = a[4:0];
        case (code)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = ~(a | b);
            5'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7: r = (a < b) ? 32'd1 : 32'd0;
            5'd8: r = b << s;
            5'd9: r = b >> s;
            5'd10: r = (b >> s) | (b[31] ? ~(32'hFFFFFFFF >> s) : 32'd0);
            5'd11: r = b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] y_model();
        ectl_t e;
        e = ctl_model(bus.op, bus.funct);
        return alu_model(e.alu, bus.rs_data, e.alusrc ? bus.ext_data : bus.rt_data);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (op=%h funct=%h)", n, act, exp, bus.op, bus.funct);
        end
    endtask

    // reference memory: cleared by reset, written at the clock edge when the model says store
    always @(posedge clk or posedge reset) begin
        ectl_t e;
        logic [31:0] y;
        if (reset)
            for (int i = 0; i < 32; i++) mm[i] <= '0;
        else begin
            e = ctl_model(bus.op, bus.funct);
            y = y_model();
            if (e.mem_w) mm[y[6:2]] <= bus.rt_data;
        end
    end

    always @(negedge clk) begin
        ectl_t e;
        logic [31:0] y, wb;
        e = ctl_model(bus.op, bus.funct);
        y = y_model();
        wb = e.mem2r ? (e.mem_r ? mm[y[6:2]] : 32'd0) : y;
        chk("jump", 32'(bus.jump), 32'(e.jump));
        chk("reg_dst", 32'(bus.reg_dst), 32'(e.reg_dst));
        chk("branch", 32'(bus.branch), 32'(e.branch));
        chk("mem_r", 32'(bus.mem_r), 32'(e.mem_r));
        chk("mem2r", 32'(bus.mem2r), 32'(e.mem2r));
        chk("mem_w", 32'(bus.mem_w), 32'(e.mem_w));
        chk("reg_w", 32'(bus.reg_w), 32'(e.reg_w));
        chk("alusrc", 32'(bus.alusrc), 32'(e.alusrc));
        chk("ext_op", 32'(bus.ext_op), 32'(e.ext));
        chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(e.alu));
        chk("alu_result", bus.alu_result, y);
        chk("zero", 32'(bus.zero), (y == 32'd0) ? 32'd1 : 32'd0);
        chk("wb_data", bus.wb_data, wb);
    end

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] x);
        bus.op = o;
        bus.funct = f;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.ext_data = x;
    endtask

    task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] x);
        @(posedge clk);
        #1 drive(o, f, a, b, x);
        @(negedge clk);
        #1;
    endtask

    logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e,
                             6'h0f, 6'h0a, 6'h0b, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h00};
    logic [5:0] functs [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2a, 6'h2b, 6'h04, 6'h06, 6'h07, 6'h00};

    initial begin
        reset = 1'b0;
        drive(6'h00, 6'h00, 32'd0, 32'd0, 32'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_reg_w", 32'(bus.reg_w), 32'd0);
        chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
        chk("rst_wb", bus.wb_data, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        apply(6'h00, 6'h20, 32'h7FFFFFFF, 32'd1, 32'd0);
        chk("add_lit", bus.alu_result, 32'h80000000);
        chk("add_reg_w", 32'(bus.reg_w), 32'd1);
        chk("add_reg_dst", 32'(bus.reg_dst), 32'd1);
        chk("add_zero", 32'(bus.zero), 32'd0);
        apply(6'h00, 6'h22, 32'h7FFFFFFF, 32'd1, 32'd0);
        chk("sub_lit", bus.alu_result, 32'h7FFFFFFE);
        apply(6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1, 32'd0);
        chk("slt_lit", bus.alu_result, 32'd1);
        apply(6'h00, 6'h2b, 32'hFFFFFFFF, 32'd1, 32'd0);
        chk("sltu_lit", bus.alu_result, 32'd0);
        apply(6'h00, 6'h07, 32'd4, 32'h80000000, 32'd0);
        chk("srav_lit", bus.alu_result, 32'hF8000000);
        apply(6'h2b, 6'h00, 32'd0, 32'hDEADBEEF, 32'd8);
        apply(6'h23, 6'h00, 32'd0, 32'd0, 32'd8);
        chk("lw_lit", bus.wb_data, 32'hDEADBEEF);
        chk("lw_mem2r", 32'(bus.mem2r), 32'd1);
        chk("lw_mem_r", 32'(bus.mem_r), 32'd1);
        apply(6'h3F, 6'h00, 32'd0, 32'd8, 32'd8);
        chk("nop_wb", bus.wb_data, 32'd8);
        apply(6'h04, 6'h00, 32'd5, 32'd5, 32'd0);
        chk("beq_branch", 32'(bus.branch), 32'd1);
        chk("beq_zero", 32'(bus.zero), 32'd1);
        chk("beq_reg_w", 32'(bus.reg_w), 32'd0);
        apply(6'h04, 6'h00, 32'd5, 32'd6, 32'd0);
        chk("bne_zero", 32'(bus.zero), 32'd0);
        apply(6'h02, 6'h00, 32'd1, 32'd2, 32'd3);
        chk("j_jump", 32'(bus.jump), 32'd1);
        chk("j_reg_w", 32'(bus.reg_w), 32'd0);
        apply(6'h0f, 6'h00, 32'd0, 32'd0, 32'h12340000);
        chk("lui_lit", bus.alu_result, 32'h12340000);
        chk("lui_ext", 32'(bus.ext_op), 32'd2);
        apply(6'h2b, 6'h00, 32'd12, 32'h55, 32'd0);
        apply(6'h23, 6'h00, 32'd12, 32'd0, 32'd0);
        chk("w3_before_rst", bus.wb_data, 32'h55);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk("w3_after_rst", bus.wb_data, 32'd0);
        apply(6'h2b, 6'h00, 32'd12, 32'h77, 32'd0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(6'h23, 6'h00, 32'd12, 32'd0, 32'd0);
        @(negedge clk);
        #1 chk("sw_in_rst", bus.wb_data, 32'd0);
        for (int n = 0; n < 400; n++) begin
            logic [5:0] o, f;
            logic [31:0] a, b, x;
            o = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : functs[$urandom_range(0, 13)];
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            x = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64));
            apply(o, f, a, b, x);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
